cpu_clk_gen: RTL and testbench

Parametrised successor to the fixed CPU clock divider. Derives the multi-cycle CPU clock Clk_CPU from the board clock clk, with a programmable divide ratio and three modes: free-run, single-step and halt. Also provides a one-cycle clock-enable pulse and a CPU cycle counter for the debug display. Sits at top level between the board clock and the multi-cycle CPU core.

---
 rtl/cpu_clk_gen_pkg.sv | 25 ++
 rtl/cpu_clk_gen_rise_detect.sv | 28 ++
 rtl/cpu_clk_gen.sv | 131 +++++++++++++
 tb/tb_cpu_clk_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_clk_pkg
// Brief   : Mode constants, FSM state encoding and helpers for cpu_clk_gen.
// Revision: 1.0
// ============================================================================
package cpu_clk_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_HALT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } clk_state_t;

    // The reserved encoding 2'b11 behaves as free-run.
    function automatic logic is_running(input logic [1:0] mode);
        return !((mode == MODE_STEP) || (mode == MODE_HALT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_clk_gen_rise_detect.sv
`default_nettype none
// ============================================================================
// Module  : rise_detect
// Brief   : Rising-edge detector; resets to "previously high" so a level held
//           through reset is not seen as an edge.
// Revision: 1.0
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= sig;
        end
    end

    assign rise = sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/cpu_clk_gen.sv
`default_nettype none
// ============================================================================
// Module  : cpu_clk_gen
// Brief   : Programmable CPU clock generator with run / single-step / halt
//           modes, clock-enable pulse and CPU cycle counter.
// Revision: 1.0
// ============================================================================
module cpu_clk_gen
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W       = 32,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_half,
    input  logic             step_req,
    output logic             Clk_CPU,
    output logic             cpu_ce,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt
);

    generate
        if (DEFAULT_DIV < 1) begin : g_default_div_check
            $error("DEFAULT_DIV must be at least 1");
        end
    endgenerate

    logic             w_step_rise;
    logic             w_run;
    logic             w_step_go;
    logic             w_tp;
    logic [DIV_W-1:0] w_n_eff;
    logic [DIV_W-1:0] w_n_cur;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_n_lat;
    clk_state_t       r_state;

    rise_detect u_step_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (step_req),
        .rise  (w_step_rise)
    );

    assign w_n_eff   = (div_half == '0) ? DIV_W'(1) : div_half;
    // The parked low phase picks up a fresh divisor when it starts counting.
    assign w_n_cur   = ((r_state == IDLE) && (r_cnt == '0)) ? w_n_eff : r_n_lat;
    assign w_tp      = (r_cnt == (w_n_cur - DIV_W'(1)));
    assign w_run     = is_running(mode);
    assign w_step_go = (mode == MODE_STEP) && w_step_rise && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_n_lat   <= DIV_W'(1);
            Clk_CPU   <= 1'b0;
            cpu_ce    <= 1'b0;
            busy      <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            cpu_ce <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_n_lat <= w_n_cur;
                    if (w_run) begin
                        if (w_tp) begin
                            r_state   <= HIGH;
                            r_cnt     <= '0;
                            r_n_lat   <= w_n_eff;
                            Clk_CPU   <= 1'b1;
                            cpu_ce    <= 1'b1;
                            cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end else begin
                            r_cnt <= r_cnt + DIV_W'(1);
                        end
                    end else if (w_step_go) begin
                        r_state   <= HIGH;
                        r_cnt     <= '0;
                        r_n_lat   <= w_n_eff;
                        Clk_CPU   <= 1'b1;
                        cpu_ce    <= 1'b1;
                        busy      <= 1'b1;
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                HIGH: begin
                    if (w_tp) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                        r_n_lat <= w_n_eff;
                        Clk_CPU <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                LOW: begin
                    if (w_tp) begin
                        r_cnt   <= '0;
                        r_n_lat <= w_n_eff;
                        busy    <= 1'b0;
                        if (w_run) begin
                            r_state   <= HIGH;
                            Clk_CPU   <= 1'b1;
                            cpu_ce    <= 1'b1;
                            cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    Clk_CPU <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_clk_gen
// Brief   : Self-checking bench for cpu_clk_gen (phase lengths, modes, counter).
// Revision: 1.0
// ============================================================================
module tb_cpu_clk_gen;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] div_half;
    logic       step_req;
    logic       Clk_CPU;
    logic       cpu_ce;
    logic       busy;
    logic [3:0] cycle_cnt;

    int total = 0;
    int bad   = 0;

    cpu_clk_gen #(.DIV_W(8), .CNT_W(4), .DEFAULT_DIV(25)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .div_half  (div_half),
        .step_req  (step_req),
        .Clk_CPU   (Clk_CPU),
        .cpu_ce    (cpu_ce),
        .busy      (busy),
        .cycle_cnt (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per expected Clk_CPU transition: level that ends, its length
    // in clk cycles (-1 = don't care) and cycle_cnt expected after a rise.
    typedef struct {
        logic lvl;
        int   len;
        int   cnt;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] div;
        int         rises;
        int         half;
    } vec_t;

    exp_t q[$];
    bit   mon_en = 1'b0;
    logic prev   = 1'b0;
    int   len    = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic rise;
        if (!rst_n) begin
            prev = 1'b0;
            len  = 0;
        end else begin
            rise = (prev == 1'b0) && (Clk_CPU == 1'b1);
            if (Clk_CPU === prev) begin
                len++;
            end else begin
                if (mon_en) begin
                    check("edge_expected", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("phase_level", int'(prev), int'(e.lvl));
                        if (e.len >= 0) check("phase_len", len, e.len);
                        if (!prev) check("cycle_cnt_at_rise", int'(cycle_cnt), e.cnt);
                    end
                end
                prev = Clk_CPU;
                len  = 1;
            end
            if (mon_en) check("cpu_ce", int'(cpu_ce), int'(rise));
        end
    end

    task automatic start_reset(input logic [1:0] m, input logic [7:0] d);
        mon_en = 1'b0;
        q.delete();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        mode     = m;
        div_half = d;
        step_req = 1'b0;
        @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain(input string name, input int limit);
        int k = 0;
        while (q.size() != 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        check(name, q.size(), 0);
    endtask

    vec_t vt[6];

    initial begin
        int bc;
        int w;

        vt[0] = '{2'b00, 8'd2, 5, 2};
        vt[1] = '{2'b00, 8'd0, 4, 1};
        vt[2] = '{2'b00, 8'd1, 17, 1};
        vt[3] = '{2'b11, 8'd3, 3, 3};
        vt[4] = '{2'b00, 8'd5, 2, 5};
        vt[5] = '{2'b00, 8'd4, 3, 4};

        rst_n    = 1'b0;
        mode     = 2'b00;
        div_half = 8'd2;
        step_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_clk_cpu", int'(Clk_CPU), 0);
        check("reset_cpu_ce", int'(cpu_ce), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_cycle_cnt", int'(cycle_cnt), 0);

        // Single step, button held through reset must not fire.
        start_reset(2'b01, 8'd3);
        step_req = 1'b1;
        release_reset();
        repeat (10) @(negedge clk);
        check("held_button_busy", int'(busy), 0);
        check("held_button_cnt", int'(cycle_cnt), 0);
        step_req = 1'b0;
        repeat (2) @(negedge clk);
        q.push_back('{1'b0, -1, 1});
        q.push_back('{1'b1, 3, 0});
        step_req = 1'b1;
        bc = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (bc == 1) step_req = 1'b0;
            if (bc == 2) step_req = 1'b1;
        end
        check("step_busy_len", bc, 6);
        check("step_queue_empty", q.size(), 0);
        check("step_cycle_cnt", int'(cycle_cnt), 1);

        step_req = 1'b0;
        repeat (2) @(negedge clk);
        q.push_back('{1'b0, -1, 2});
        step_req = 1'b1;
        drain("step2_rise", 10);
        @(negedge clk);
        check("step2_busy", int'(busy), 1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_clk_cpu", int'(Clk_CPU), 0);
        check("async_rst_cpu_ce", int'(cpu_ce), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_cycle_cnt", int'(cycle_cnt), 0);

        // Free-run vectors.
        foreach (vt[v]) begin
            start_reset(vt[v].mode, vt[v].div);
            for (int i = 1; i <= vt[v].rises; i++) begin
                q.push_back('{1'b0, vt[v].half, i % 16});
                if (i < vt[v].rises) q.push_back('{1'b1, vt[v].half, 0});
            end
            release_reset();
            drain("run_vector", 2 * vt[v].half * vt[v].rises + 10);
        end

        // Halt in the middle of a high phase, then resume.
        start_reset(2'b00, 8'd4);
        q.push_back('{1'b0, 4, 1});
        release_reset();
        drain("halt_first_rise", 20);
        @(negedge clk);
        mode = 2'b10;
        q.push_back('{1'b1, 4, 0});
        drain("halt_high_done", 20);
        repeat (20) @(negedge clk);
        check("halt_parked_low", int'(Clk_CPU), 0);
        check("halt_cnt_frozen", int'(cycle_cnt), 1);
        q.push_back('{1'b0, -1, 2});
        q.push_back('{1'b1, 4, 0});
        q.push_back('{1'b0, 4, 3});
        mode = 2'b00;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!Clk_CPU && w < 20);
        check("halt_resume_delay", w, 4);
        drain("halt_resume_run", 30);

        // Divisor change mid high phase.
        start_reset(2'b00, 8'd4);
        q.push_back('{1'b0, 4, 1});
        release_reset();
        drain("div_first_rise", 20);
        @(negedge clk);
        div_half = 8'd2;
        q.push_back('{1'b1, 4, 0});
        q.push_back('{1'b0, 2, 2});
        q.push_back('{1'b1, 2, 0});
        q.push_back('{1'b0, 2, 3});
        drain("div_change", 40);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
